// File: rtl/uart_fetch_pkg.sv
// ============================================================================
// Module   : uart_fetch_pkg
// Purpose  : Shared state encoding and timeout defaults for the UART fetch
//            controller and its timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_fetch_pkg;

  localparam int unsigned c_TIMEOUT_DEFAULT = 1000000;
  localparam int unsigned c_TIMEOUT_CNT_W   = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TX_SEND   = 3'd1,
    ST_TX_WAIT   = 3'd2,
    ST_RX_HI     = 3'd3,
    ST_RX_LO     = 3'd4,
    ST_EXEC      = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_PC_UPD    = 3'd7
  } fetch_state_e;

  // States that block on an external handshake and are therefore time-limited.
  function automatic logic is_wait_state(input fetch_state_e s);
    return (s == ST_TX_WAIT) || (s == ST_RX_HI) ||
           (s == ST_RX_LO)   || (s == ST_WAIT_DONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_timeout_cnt.sv
// ============================================================================
// Module   : fetch_timeout_cnt
// Purpose  : Wait-state cycle counter with synchronous clear and a terminal
//            count flag at TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_timeout_cnt
  import uart_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [c_TIMEOUT_CNT_W-1:0] c_TERMINAL = c_TIMEOUT_CNT_W'(TIMEOUT - 1);

  logic [c_TIMEOUT_CNT_W-1:0] r_count;
  logic                       w_at_terminal;

  assign w_at_terminal = (r_count == c_TERMINAL);
  assign tc            = enable && w_at_terminal;

  // Holds at the terminal value so a stalled clear can never wrap the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_terminal) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_fetch_ctrl.sv
// ============================================================================
// Module   : uart_fetch_ctrl
// Purpose  : Fetch/execute sequencer: sends the PC over UART, assembles the
//            two-byte reply into an instruction, runs the CPU, advances PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fetch_ctrl
  import uart_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  pc_addr,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        cpu_run,
  input  logic        cpu_done,
  output logic        pc_en,
  output logic [15:0] instr,
  output logic        busy,
  output logic        err
);

  fetch_state_e r_state;

  logic w_awaited;
  logic w_cnt_en;
  logic w_cnt_clear;
  logic w_tmo_tc;

  always_comb begin
    w_awaited = 1'b0;
    case (r_state)
      ST_TX_WAIT:         w_awaited = tx_done;
      ST_RX_HI, ST_RX_LO: w_awaited = rx_done;
      ST_WAIT_DONE:       w_awaited = cpu_done;
      default:            w_awaited = 1'b0;
    endcase
  end

  // Clearing on every exit from a wait state means each state is entered
  // with a zero count; non-wait states keep the counter parked at zero.
  assign w_cnt_en    = is_wait_state(r_state);
  assign w_cnt_clear = !w_cnt_en || w_awaited || w_tmo_tc;

  fetch_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_cnt_clear),
    .enable (w_cnt_en),
    .tc     (w_tmo_tc)
  );

  // Pulse outputs are set on the edge that enters their state, so each is
  // high exactly while the FSM sits in TX_SEND, EXEC or PC_UPD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      cpu_run  <= 1'b0;
      pc_en    <= 1'b0;
      instr    <= 16'h0000;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      cpu_run  <= 1'b0;
      pc_en    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (err) begin
            if (!run) begin
              err <= 1'b0;
            end
          end else if (run) begin
            tx_data  <= pc_addr;
            r_state  <= ST_TX_SEND;
            tx_start <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_TX_SEND: begin
          r_state <= ST_TX_WAIT;
        end

        ST_TX_WAIT: begin
          if (tx_done) begin
            r_state <= ST_RX_HI;
          end else if (w_tmo_tc) begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_RX_HI: begin
          if (rx_done) begin
            instr[15:8] <= rx_data;
            r_state     <= ST_RX_LO;
          end else if (w_tmo_tc) begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_RX_LO: begin
          if (rx_done) begin
            instr[7:0] <= rx_data;
            r_state    <= ST_EXEC;
            cpu_run    <= 1'b1;
          end else if (w_tmo_tc) begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_EXEC: begin
          r_state <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          if (cpu_done) begin
            r_state <= ST_PC_UPD;
            pc_en   <= 1'b1;
          end else if (w_tmo_tc) begin
            err     <= 1'b1;
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end

        ST_PC_UPD: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_fetch_ctrl.sv
// ============================================================================
// Module   : tb_uart_fetch_ctrl
// Purpose  : Scoreboard bench for uart_fetch_ctrl with randomized handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_fetch_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  pc_addr = 8'h00;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cpu_run;
  logic        cpu_done = 1'b0;
  logic        pc_en;
  logic [15:0] instr;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  uart_fetch_ctrl #(
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .pc_addr  (pc_addr),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .cpu_run  (cpu_run),
    .cpu_done (cpu_done),
    .pc_en    (pc_en),
    .instr    (instr),
    .busy     (busy),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef enum int {EV_TX, EV_CPU, EV_PC, EV_ERR, EV_ERR_CLR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [15:0] data;
  } ev_t;

  ev_t sb[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void expect_ev(input ev_kind_e k, input logic [15:0] d);
    sb.push_back('{kind: k, data: d});
  endfunction

  function automatic void pop_cmp(input ev_kind_e k, input logic [15:0] act, input string name);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got event (data 0x%0h), expected no event", name, act);
    end else begin
      e = sb.pop_front();
      if (e.kind != k) begin
        n_checks++;
        n_fail++;
        $display("FAIL order_%s: got event kind %0d, expected kind %0d", name, k, e.kind);
      end else begin
        chk(name, {16'h0, act}, {16'h0, e.data});
      end
    end
  endfunction

  // Monitor: every visible DUT event is matched against the scoreboard.
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (tx_start || cpu_run || pc_en)
        chk("pulse_exclusive", 32'(int'(tx_start) + int'(cpu_run) + int'(pc_en)), 32'd1);
      if (tx_start) pop_cmp(EV_TX, {8'h00, tx_data}, "tx_data");
      if (cpu_run)  pop_cmp(EV_CPU, instr, "instr");
      if (pc_en)    pop_cmp(EV_PC, 16'h0000, "pc_en");
      if (err && !prev_err) pop_cmp(EV_ERR, 16'h0000, "err_set");
      if (!err && prev_err) pop_cmp(EV_ERR_CLR, 16'h0000, "err_clr");
    end
    prev_err <= err;
  end

  // which: 0 = tx_done, 1 = rx_done, 2 = cpu_done. Non-awaited strobes are noise.
  task automatic drive_noise(input int which, input bit noise, input int k);
    bit fire;
    fire     = noise && ((k == 0) || ($urandom_range(0, 1) == 1));
    tx_done  = (which != 0) && fire;
    cpu_done = (which != 2) && noise && ($urandom_range(0, 1) == 1);
    rx_done  = (which != 1) && fire;
    if (rx_done) rx_data = 8'hAA;
  endtask

  // Entered at the negedge of the first cycle of a waiting state.
  task automatic phase(input int d, input int which, input logic [7:0] data,
                       input bit noise, output bit to);
    int lim;
    lim = (d >= TMO) ? TMO : d;
    for (int k = 0; k < lim; k++) begin
      drive_noise(which, noise, k);
      if (d >= TMO && k == TMO - 1) begin
        chk("err_before_terminal", {31'h0, err}, 32'd0);
        chk("busy_while_waiting", {31'h0, busy}, 32'd1);
      end
      @(negedge clk);
    end
    tx_done  = 1'b0;
    rx_done  = 1'b0;
    cpu_done = 1'b0;
    if (d >= TMO) begin
      chk("err_after_timeout", {31'h0, err}, 32'd1);
      chk("busy_after_timeout", {31'h0, busy}, 32'd0);
      to = 1'b1;
    end else begin
      case (which)
        0:       tx_done = 1'b1;
        1:       begin rx_done = 1'b1; rx_data = data; end
        default: cpu_done = 1'b1;
      endcase
      @(negedge clk);
      tx_done  = 1'b0;
      rx_done  = 1'b0;
      cpu_done = 1'b0;
      rx_data  = 8'($urandom);
      to = 1'b0;
    end
  endtask

  // One fetch loop. A phase delay >= TMO means that response never comes.
  task automatic do_loop(input logic [7:0] pc, input int dtx, input int dhi,
                         input int dlo, input int dcpu, input logic [7:0] hi,
                         input logic [7:0] lo, input bit noise, input bit drop_run);
    int d[4];
    int first;
    int t0;
    bit to;
    d = '{dtx, dhi, dlo, dcpu};
    first = 4;
    for (int i = 3; i >= 0; i--) if (d[i] >= TMO) first = i;

    expect_ev(EV_TX, {8'h00, pc});
    if (first >= 3) expect_ev(EV_CPU, {hi, lo});
    if (first == 4) expect_ev(EV_PC, 16'h0000);
    else begin
      expect_ev(EV_ERR, 16'h0000);
      expect_ev(EV_ERR_CLR, 16'h0000);
    end

    run     = 1'b1;
    pc_addr = pc;
    t0      = cycle;
    to      = 1'b0;
    @(negedge clk);
    chk("tx_start_after_idle", {31'h0, tx_start}, 32'd1);
    pc_addr = 8'($urandom);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == 2 && drop_run) run = 1'b0;
      if (i == 3) @(negedge clk);
      phase(d[i], (i == 0) ? 0 : ((i == 3) ? 2 : 1), (i == 1) ? hi : lo, noise, to);
      if (to) break;
    end

    if (to) begin
      run = 1'b0;
      @(negedge clk);
      chk("err_cleared_by_run_low", {31'h0, err}, 32'd0);
      return;
    end

    @(negedge clk);
    chk("busy_back_in_idle", {31'h0, busy}, 32'd0);
    if (dtx == 0 && dhi == 0 && dlo == 0 && dcpu == 0)
      chk("min_loop_latency", 32'(cycle - t0), 32'd8);
    if (drop_run) begin
      repeat (4) @(negedge clk);
      chk("idle_after_run_drop", {31'h0, busy}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_start"}, {31'h0, tx_start}, 32'd0);
    chk({tag, "_cpu_run"},  {31'h0, cpu_run},  32'd0);
    chk({tag, "_pc_en"},    {31'h0, pc_en},    32'd0);
    chk({tag, "_busy"},     {31'h0, busy},     32'd0);
    chk({tag, "_err"},      {31'h0, err},      32'd0);
    chk({tag, "_tx_data"},  {24'h0, tx_data},  32'd0);
    chk({tag, "_instr"},    {16'h0, instr},    32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit to;
    int dd[4];
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Happy path, spurious strobes, boundary, timeout, run drop.
    do_loop(8'h05, 3, 0, 0, 0, 8'h12, 8'h34, 1'b0, 1'b0);
    do_loop(8'h21, 4, 1, 2, 1, 8'h12, 8'h34, 1'b1, 1'b0);
    do_loop(8'h33, 2, TMO - 1, 1, 3, 8'hC3, 8'h3C, 1'b0, 1'b0);
    do_loop(8'h44, 1, TMO, 0, 0, 8'h55, 8'h66, 1'b0, 1'b0);
    do_loop(8'h45, TMO - 1, 0, TMO - 1, TMO - 1, 8'h77, 8'h88, 1'b1, 1'b0);
    do_loop(8'h46, 0, 0, 0, TMO, 8'h99, 8'hAB, 1'b0, 1'b0);
    do_loop(8'h50, 1, 1, 2, 2, 8'hDE, 8'hAD, 1'b0, 1'b1);
    do_loop(8'h60, 0, 0, 0, 0, 8'h01, 8'h02, 1'b0, 1'b0);
    do_loop(8'h61, 0, 0, 0, 0, 8'h03, 8'h04, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        dd[i] = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, TMO - 1);
      do_loop(8'($urandom), dd[0], dd[1], dd[2], dd[3], 8'($urandom), 8'($urandom),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    run = 1'b0;
    @(negedge clk);

    // Reset while waiting for cpu_done: the loop is abandoned with no pc_en.
    expect_ev(EV_TX, 16'h005A);
    expect_ev(EV_CPU, 16'hBEEF);
    run     = 1'b1;
    pc_addr = 8'h5A;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    phase(1, 0, 8'h00, 1'b0, to);
    phase(0, 1, 8'hBE, 1'b0, to);
    phase(2, 1, 8'hEF, 1'b0, to);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_all_zero("midloop_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_reset_release", {31'h0, busy}, 32'd0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_fetch_ctrl.md
UART_FETCH_CTRL -- requirements
Module: uart_fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000, meaning wait-state cycle limit before error (legal range 2..2^20-1).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port run, input, 1, level enable for the fetch/execute loop.
REQ-005 SHALL have port pc_addr, input, 8, current program counter value.
REQ-006 SHALL have port tx_start, output, 1, one-cycle request to the UART transmitter.
REQ-007 SHALL have port tx_data, output, 8, byte to transmit (latched PC).
REQ-008 SHALL have port tx_done, input, 1, one-cycle pulse when the UART transmit completes.
REQ-009 SHALL have port rx_done, input, 1, one-cycle pulse when a received byte is valid.
REQ-010 SHALL have port rx_data, input, 8, received byte, valid while rx_done=1.
REQ-011 SHALL have port cpu_run, output, 1, one-cycle start pulse to the CPU.
REQ-012 SHALL have port cpu_done, input, 1, CPU instruction-complete pulse.
REQ-013 SHALL have port pc_en, output, 1, one-cycle PC-update enable.
REQ-014 SHALL have port instr, output, 16, assembled instruction register.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-016 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-017 SHALL implement states IDLE, TX_SEND, TX_WAIT, RX_HI, RX_LO, EXEC, WAIT_DONE, PC_UPD.
REQ-018 In IDLE with run=1 and err=0: capture pc_addr into tx_data, go to TX_SEND next cycle.
REQ-019 TX_SEND: tx_start=1 for exactly that cycle, then go to TX_WAIT unconditionally.
REQ-020 TX_WAIT: on tx_done, go to RX_HI; rx_done and cpu_done are ignored in this state.
REQ-021 RX_HI: on rx_done, load instr[15:8]<=rx_data, go to RX_LO; high byte always first.
REQ-022 RX_LO: on rx_done, load instr[7:0]<=rx_data, go to EXEC; instr is otherwise held.
REQ-023 EXEC: cpu_run=1 for exactly one cycle, then go to WAIT_DONE.
REQ-024 WAIT_DONE: on cpu_done, go to PC_UPD; PC_UPD: pc_en=1 for one cycle, then go to IDLE.
REQ-025 tx_start, cpu_run and pc_en SHALL be decoded from state only (Moore outputs); never asserted in the same cycle.
REQ-026 Minimum loop latency (all responses immediate) SHALL be 8 cycles IDLE-to-IDLE.
REQ-027 A timeout counter SHALL clear on every state entry and count each cycle in TX_WAIT, RX_HI, RX_LO and WAIT_DONE.
REQ-028 When the counter reaches TIMEOUT-1 with no awaited event: set err=1, go to IDLE, suppress cpu_run/pc_en.
REQ-029 An awaited event arriving in the same cycle as the timeout terminal count SHALL win; err is not set.
REQ-030 run deasserting mid-loop SHALL NOT abort; the loop completes through PC_UPD and then stays in IDLE.
REQ-031 err SHALL hold the FSM in IDLE; err clears when the FSM is in IDLE with run=0 for one cycle.
REQ-032 Pulses of tx_done, rx_done or cpu_done arriving outside their awaited state SHALL be dropped, never queued.

Reset
REQ-033 On reset=0: state=IDLE, tx_data=0, instr=0, err=0, counter=0; tx_start=cpu_run=pc_en=busy=0, immediately and asynchronously.
REQ-034 Reset asserted mid-loop SHALL abandon the transaction with no pc_en or cpu_run pulse after release.

Structure
REQ-035 State encodings (3-bit) and the default TIMEOUT value SHALL live in shared package uart_fetch_pkg.
REQ-036 The timeout counter SHALL be a sub-module fetch_timeout_cnt (clear, enable, terminal-count output).

Verification
REQ-037 Happy path: pc_addr=0x05, run=1, tx_done after 3 cycles, rx bytes 0x12,0x34 -> tx_data=0x05, instr=0x1234, one cpu_run, one pc_en after cpu_done.
REQ-038 Timeout: TIMEOUT=16, no rx_done after tx_done -> err=1 16 cycles after RX_HI entry, FSM in IDLE, no cpu_run.
REQ-039 Boundary: TIMEOUT=16, rx_done exactly on the terminal cycle -> err stays 0, instr high byte loaded.
REQ-040 Spurious: rx_done=1 (0xAA) during TX_WAIT, then 0x12,0x34 -> instr=0x1234.
REQ-041 Run drop: run=0 during RX_LO -> loop completes with one pc_en, then busy=0 and no new tx_start.
REQ-042 Reset mid-WAIT_DONE -> all outputs 0 immediately; cpu_done after release produces no pc_en.
